ex_stage_pipe: RTL and testbench
================================

Name: ex_stage_pipe

Overview:
Parametrised pipelined execute stage for the ARMv8 core, with the EX/MEM pipeline register built in. It adds operand forwarding from MEM/WB and a registered branch target/decision for B/CBZ/CBNZ. It also has a multi-cycle iterative MUL with a busy/stall handshake to ID/EX, and holds or flushes under downstream stall or branch flush.

Parameters:
DATA_W, 64, datapath width (pc, operands, result)
REG_AW, 5, register address width; register 31 is XZR
MUL_BITS, 4, multiplier bits retired per cycle; must divide DATA_W; MUL_STEPS N = DATA_W/MUL_BITS

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  ID/EX holds a valid instruction
in_pc  in  DATA_W  instruction pc
in_rs1_data, in_rs2_data  in  DATA_W  register-file operands
in_imm  in  DATA_W  sign-extended immediate
in_rs1, in_rs2, in_rd  in  REG_AW  source/destination register numbers
in_alu_op  in  4  ALU operation (package encoding)
in_alu_src  in  1  1: B operand = in_imm; 0: forwarded rs2
in_br_type  in  2  00 none, 01 B, 10 CBZ, 11 CBNZ
in_mem_read, in_mem_write, in_reg_write  in  1  control bits carried to MEM/WB
mem_fwd_en, wb_fwd_en  in  1  forwarding sources valid and writing a register
mem_fwd_rd, wb_fwd_rd  in  REG_AW  forwarding destination register
mem_fwd_data, wb_fwd_data  in  DATA_W  forwarding values
mem_stall  in  1  MEM cannot accept; EX/MEM holds
flush  in  1  squash the instruction in EX
ex_busy  out  1  EX cannot accept; ID/EX must hold
out_valid  out  1  EX/MEM valid
out_alu_result  out  DATA_W  result
out_zero  out  1  out_alu_result == 0
out_br_target  out  DATA_W  in_pc + (in_imm << 2)
out_br_taken  out  1  branch decision
out_write_data  out  DATA_W  forwarded rs2, for stores
out_rd  out  REG_AW
out_mem_read, out_mem_write, out_reg_write  out  1

Behaviour:
- Reset: all out_* = 0 and FSM = IDLE, so ex_busy = 0. Reset mid-MUL aborts the multiply.
- Forwarding, per operand, combinational at acceptance:
  - MEM match has priority over WB, then the register-file value.
  - A match requires fwd_en, fwd_rd == rs, and rs != 31.
- Operand B = in_alu_src ? in_imm : fwd_rs2. out_write_data is always fwd_rs2.
- ALU ops: AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111, NOR 1100, MUL 1000. Undefined codes give result 0 in a single cycle.
- Arithmetic: all results wrap mod 2^DATA_W. MUL returns the low DATA_W bits of the product. Branch target also wraps.
- Branch decision: B → taken = 1. CBZ → taken = zero. CBNZ → taken = !zero. The decoder issues PASSB for CBZ/CBNZ.
- Accept condition: in_valid & !ex_busy & !mem_stall & !flush.
- Single-cycle ops: EX/MEM is loaded on the accepting edge, so latency is 1.
- If not accepting, mem_stall = 0 and no result is pending: EX/MEM loads a bubble (out_valid = 0; mem_read, mem_write, reg_write, br_taken all 0).
- FSM states IDLE, MUL, DONE; ex_busy = (state != IDLE).
  - IDLE → MUL on accepting a MUL. Latch the operands, clear the accumulator, cnt = 0; EX/MEM gets a bubble.
  - MUL: retire MUL_BITS bits per edge. When cnt == N−1, the next state is DONE if mem_stall, else IDLE with EX/MEM loaded with the product.
  - DONE: hold the product; load EX/MEM and go to IDLE on the first edge with !mem_stall.
  - ex_busy is therefore high for exactly N cycles when unstalled. Forwarding is sampled only at acceptance.
- mem_stall = 1: every EX/MEM field holds; the MUL step counter continues.
- flush = 1: kills the EX instruction. The incoming instruction is not accepted and the FSM returns to IDLE (product discarded).
  - If mem_stall = 0, EX/MEM loads a bubble.
  - If mem_stall = 1, EX/MEM holds.
  - reset > flush > mem_stall in priority.
- out_zero and out_br_taken are registered with the result they describe.

Decomposition:
- ex_pkg holds:
  - ALU op codes and branch-type encodings
  - XZR = 31
  - FSM state enum
- Sub-module iter_mul (DATA_W, MUL_BITS): start, operands, done pulse, product. It is a shift-add unit with a step counter.
- ALU and forwarding muxes stay inline.

Test Plan:
- ADD, in_rs1_data = 5, in_alu_src = 1, in_imm = 0xFFFF_FFFF_FFFF_FFFD → after 1 edge: out_valid = 1, result 2, out_zero = 0.
- SUB, rs1 = rs2 = 3:
  - Inputs: in_rs1_data = 1, in_rs2_data = 10; mem_fwd rd 3 = 10; wb_fwd rd 3 = 20 → result 0, out_zero = 1 (MEM priority).
  - Repeat with rs1 = 31 and forward rd = 31, in_rs1_data = 0 → result −10 (0xFFFF_FFFF_FFFF_FFF6).
- MUL 7 × 6, MUL_BITS = 4 → ex_busy high 16 cycles, out_valid 0 meanwhile, then out_alu_result = 42.
  - MUL 0xFFFF_FFFF_FFFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
- CBZ, pc = 0x100, imm = 4, rs2 = 0 → out_br_target = 0x110, out_br_taken = 1. Same with CBNZ → out_br_taken = 0. B → 1 regardless.
- MUL with mem_stall high from step 10 to step 20 → FSM holds in DONE, out_* unchanged, product loaded on the first edge after mem_stall falls.
- Flush at MUL step 5 → ex_busy = 0 next cycle, out_valid = 0, no product ever appears. Reset at MUL step 5 → all outputs 0 next edge.

Source files
------------

// File: rtl/ex_stage_pipe_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch types,
// the zero register and the multiply FSM states.
package ex_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_B    = 2'b01;
    localparam logic [1:0] BR_CBZ  = 2'b10;
    localparam logic [1:0] BR_CBNZ = 2'b11;

    localparam int unsigned XZR = 31;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic br_decide(
        input logic [1:0] t,
        input logic       z
    );
        case (t)
            BR_B:    return 1'b1;
            BR_CBZ:  return z;
            BR_CBNZ: return !z;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// ID/EX inputs, forwarding sources, MEM back-pressure and the
// EX/MEM register outputs of the execute stage.
interface ex_stage_pipe_if #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic [DATA_W-1:0] in_imm;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic [3:0]        in_alu_op;
    logic              in_alu_src;
    logic [1:0]        in_br_type;
    logic              in_mem_read;
    logic              in_mem_write;
    logic              in_reg_write;

    logic              mem_fwd_en;
    logic [REG_AW-1:0] mem_fwd_rd;
    logic [DATA_W-1:0] mem_fwd_data;
    logic              wb_fwd_en;
    logic [REG_AW-1:0] wb_fwd_rd;
    logic [DATA_W-1:0] wb_fwd_data;

    logic              mem_stall;
    logic              flush;
    logic              ex_busy;

    logic              out_valid;
    logic [DATA_W-1:0] out_alu_result;
    logic              out_zero;
    logic [DATA_W-1:0] out_br_target;
    logic              out_br_taken;
    logic [DATA_W-1:0] out_write_data;
    logic [REG_AW-1:0] out_rd;
    logic              out_mem_read;
    logic              out_mem_write;
    logic              out_reg_write;

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data,
        output in_imm, in_rs1, in_rs2, in_rd, in_alu_op,
        output in_alu_src, in_br_type, in_mem_read,
        output in_mem_write, in_reg_write,
        output mem_fwd_en, mem_fwd_rd, mem_fwd_data,
        output wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        output mem_stall, flush,
        input  ex_busy, out_valid, out_alu_result, out_zero,
        input  out_br_target, out_br_taken, out_write_data,
        input  out_rd, out_mem_read, out_mem_write,
        input  out_reg_write
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data,
        input  in_imm, in_rs1, in_rs2, in_rd, in_alu_op,
        input  in_alu_src, in_br_type, in_mem_read,
        input  in_mem_write, in_reg_write,
        input  mem_fwd_en, mem_fwd_rd, mem_fwd_data,
        input  wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        input  mem_stall, flush,
        output ex_busy, out_valid, out_alu_result, out_zero,
        output out_br_target, out_br_taken, out_write_data,
        output out_rd, out_mem_read, out_mem_write,
        output out_reg_write
    );

endinterface

// File: rtl/ex_stage_pipe_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits
// per cycle; product is the low DATA_W bits.
module iter_mul #(
    parameter int DATA_W   = 64,
    parameter int MUL_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int N  = DATA_W / MUL_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic              run_q, run_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] digit;
    logic              last;

    assign digit = DATA_W'(b_q[MUL_BITS-1:0]);
    assign last  = (cnt_q == CW'(N - 1));

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        done  = 1'b0;
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            a_d   = a;
            b_d   = b;
            acc_d = '0;
        end else if (abort) begin
            run_d = 1'b0;
        end else if (run_q) begin
            acc_d = acc_q + a_q * digit;
            a_d   = a_q << MUL_BITS;
            b_d   = b_q >> MUL_BITS;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                run_d = 1'b0;
                done  = 1'b1;
            end
        end
    end

    // Next accumulator value: the finished product on the done step,
    // and the held product once idle.
    assign product = acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage with operand forwarding, branch resolution, an
// iterative multiplier and the EX/MEM pipeline register.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int MUL_BITS = 4
) (
    input logic           clk,
    input logic           reset,
    ex_stage_pipe_if.slave bus
);

    logic [1:0]        state_q, state_d;
    logic              accept, is_mul;
    logic              mul_start, mul_done;
    logic              do_bubble, do_alu, do_prod;
    logic [DATA_W-1:0] fwd_a, fwd_b, op_b;
    logic [DATA_W-1:0] alu_res, br_tgt, mul_prod;
    logic              alu_zero;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] tgt_q, tgt_d;
    logic              taken_q, taken_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              mr_q, mr_d;
    logic              mw_q, mw_d;
    logic              rw_q, rw_d;

    logic [DATA_W-1:0] m_tgt_q, m_tgt_d;
    logic [DATA_W-1:0] m_wd_q, m_wd_d;
    logic [REG_AW-1:0] m_rd_q, m_rd_d;
    logic              m_mr_q, m_mr_d;
    logic              m_mw_q, m_mw_d;
    logic              m_rw_q, m_rw_d;

    function automatic logic hit(
        input logic              en,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs
    );
        return en && (rd == rs) && (rs != REG_AW'(XZR));
    endfunction

    assign bus.ex_busy = (state_q != S_IDLE);
    assign is_mul      = (bus.in_alu_op == OP_MUL);
    assign accept      = bus.in_valid & !bus.ex_busy
                       & !bus.mem_stall & !bus.flush;

    always_comb begin
        fwd_a = bus.in_rs1_data;
        if (hit(bus.mem_fwd_en, bus.mem_fwd_rd, bus.in_rs1))
            fwd_a = bus.mem_fwd_data;
        else if (hit(bus.wb_fwd_en, bus.wb_fwd_rd, bus.in_rs1))
            fwd_a = bus.wb_fwd_data;
    end

    always_comb begin
        fwd_b = bus.in_rs2_data;
        if (hit(bus.mem_fwd_en, bus.mem_fwd_rd, bus.in_rs2))
            fwd_b = bus.mem_fwd_data;
        else if (hit(bus.wb_fwd_en, bus.wb_fwd_rd, bus.in_rs2))
            fwd_b = bus.wb_fwd_data;
    end

    assign op_b   = bus.in_alu_src ? bus.in_imm : fwd_b;
    assign br_tgt = bus.in_pc + (bus.in_imm << 2);

    always_comb begin
        alu_res = '0;
        case (bus.in_alu_op)
            OP_AND:   alu_res = fwd_a & op_b;
            OP_ORR:   alu_res = fwd_a | op_b;
            OP_ADD:   alu_res = fwd_a + op_b;
            OP_SUB:   alu_res = fwd_a - op_b;
            OP_PASSB: alu_res = op_b;
            OP_NOR:   alu_res = ~(fwd_a | op_b);
            default:  alu_res = '0;
        endcase
    end

    assign alu_zero = (alu_res == '0);

    iter_mul #(
        .DATA_W  (DATA_W),
        .MUL_BITS(MUL_BITS)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .abort  (bus.flush),
        .a      (fwd_a),
        .b      (op_b),
        .done   (mul_done),
        .product(mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        do_bubble = 1'b0;
        do_alu    = 1'b0;
        do_prod   = 1'b0;
        if (bus.flush) begin
            state_d   = S_IDLE;
            do_bubble = !bus.mem_stall;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                        do_bubble = 1'b1;
                    end else if (accept) begin
                        do_alu = 1'b1;
                    end else begin
                        do_bubble = !bus.mem_stall;
                    end
                end
                S_MUL: begin
                    if (mul_done && bus.mem_stall) begin
                        state_d = S_DONE;
                    end else if (mul_done) begin
                        state_d = S_IDLE;
                        do_prod = 1'b1;
                    end else begin
                        do_bubble = !bus.mem_stall;
                    end
                end
                S_DONE: begin
                    if (!bus.mem_stall) begin
                        state_d = S_IDLE;
                        do_prod = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Write-back metadata of a multiply is captured at acceptance
    // because ID/EX moves on while the product is being built.
    always_comb begin
        m_tgt_d = m_tgt_q;
        m_wd_d  = m_wd_q;
        m_rd_d  = m_rd_q;
        m_mr_d  = m_mr_q;
        m_mw_d  = m_mw_q;
        m_rw_d  = m_rw_q;
        if (mul_start) begin
            m_tgt_d = br_tgt;
            m_wd_d  = fwd_b;
            m_rd_d  = bus.in_rd;
            m_mr_d  = bus.in_mem_read;
            m_mw_d  = bus.in_mem_write;
            m_rw_d  = bus.in_reg_write;
        end
    end

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        zero_d  = zero_q;
        tgt_d   = tgt_q;
        taken_d = taken_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        rw_d    = rw_q;
        if (do_alu) begin
            valid_d = 1'b1;
            res_d   = alu_res;
            zero_d  = alu_zero;
            tgt_d   = br_tgt;
            taken_d = br_decide(bus.in_br_type, alu_zero);
            wd_d    = fwd_b;
            rd_d    = bus.in_rd;
            mr_d    = bus.in_mem_read;
            mw_d    = bus.in_mem_write;
            rw_d    = bus.in_reg_write;
        end else if (do_prod) begin
            valid_d = 1'b1;
            res_d   = mul_prod;
            zero_d  = (mul_prod == '0);
            tgt_d   = m_tgt_q;
            taken_d = 1'b0;
            wd_d    = m_wd_q;
            rd_d    = m_rd_q;
            mr_d    = m_mr_q;
            mw_d    = m_mw_q;
            rw_d    = m_rw_q;
        end else if (do_bubble) begin
            valid_d = 1'b0;
            taken_d = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            rw_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            tgt_q   <= '0;
            taken_q <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            rw_q    <= 1'b0;
            m_tgt_q <= '0;
            m_wd_q  <= '0;
            m_rd_q  <= '0;
            m_mr_q  <= 1'b0;
            m_mw_q  <= 1'b0;
            m_rw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            tgt_q   <= tgt_d;
            taken_q <= taken_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            rw_q    <= rw_d;
            m_tgt_q <= m_tgt_d;
            m_wd_q  <= m_wd_d;
            m_rd_q  <= m_rd_d;
            m_mr_q  <= m_mr_d;
            m_mw_q  <= m_mw_d;
            m_rw_q  <= m_rw_d;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_alu_result = res_q;
    assign bus.out_zero       = zero_q;
    assign bus.out_br_target  = tgt_q;
    assign bus.out_br_taken   = taken_q;
    assign bus.out_write_data = wd_q;
    assign bus.out_rd         = rd_q;
    assign bus.out_mem_read   = mr_q;
    assign bus.out_mem_write  = mw_q;
    assign bus.out_reg_write  = rw_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: ALU/branch vector table plus
// multiply, stall, flush and reset sequences.
module tb_ex_stage_pipe;
    import ex_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    ex_stage_pipe #(
        .DATA_W  (DW),
        .REG_AW  (AW),
        .MUL_BITS(MB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  br;
        logic        src;
        logic [63:0] pc;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        men;
        logic [4:0]  mrd;
        logic [63:0] mdat;
        logic        wen;
        logic [4:0]  wrd;
        logic [63:0] wdat;
        logic [63:0] e_res;
        logic        e_zero;
        logic        e_taken;
        logic [63:0] e_tgt;
        logic [63:0] e_wd;
    } vec_t;

    vec_t vt[16];
    int n_chk = 0;
    int n_err = 0;

    function automatic vec_t mk(
        input logic [3:0]  op,
        input logic [1:0]  br,
        input logic        src,
        input logic [63:0] pc,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] imm,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [63:0] res,
        input logic        z,
        input logic        tk,
        input logic [63:0] tgt,
        input logic [63:0] wd
    );
        vec_t v;
        v.op = op; v.br = br; v.src = src; v.pc = pc;
        v.a = a; v.b = b; v.imm = imm;
        v.rs1 = rs1; v.rs2 = rs2;
        v.men = 1'b0; v.mrd = '0; v.mdat = '0;
        v.wen = 1'b0; v.wrd = '0; v.wdat = '0;
        v.e_res = res; v.e_zero = z; v.e_taken = tk;
        v.e_tgt = tgt; v.e_wd = wd;
        return v;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.in_valid = 0; bus.in_pc = '0;
        bus.in_rs1_data = '0; bus.in_rs2_data = '0;
        bus.in_imm = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_rd = '0; bus.in_alu_op = '0;
        bus.in_alu_src = 0; bus.in_br_type = '0;
        bus.in_mem_read = 0; bus.in_mem_write = 0;
        bus.in_reg_write = 0;
        bus.mem_fwd_en = 0; bus.mem_fwd_rd = '0;
        bus.mem_fwd_data = '0;
        bus.wb_fwd_en = 0; bus.wb_fwd_rd = '0;
        bus.wb_fwd_data = '0;
        bus.mem_stall = 0; bus.flush = 0;
    endtask

    task automatic drive(input vec_t v, input logic [4:0] rd);
        bus.in_alu_op = v.op; bus.in_br_type = v.br;
        bus.in_alu_src = v.src; bus.in_pc = v.pc;
        bus.in_rs1_data = v.a; bus.in_rs2_data = v.b;
        bus.in_imm = v.imm;
        bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
        bus.mem_fwd_en = v.men; bus.mem_fwd_rd = v.mrd;
        bus.mem_fwd_data = v.mdat;
        bus.wb_fwd_en = v.wen; bus.wb_fwd_rd = v.wrd;
        bus.wb_fwd_data = v.wdat;
        bus.in_rd = rd; bus.in_reg_write = 1;
    endtask

    task automatic issue_mul(
        input logic [63:0] a,
        input logic [63:0] b
    );
        clr();
        bus.in_alu_op = OP_MUL;
        bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2;
        bus.in_rs1_data = a; bus.in_rs2_data = b;
        bus.in_rd = 5'd9; bus.in_reg_write = 1;
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
    endtask

    task automatic run_mul(
        input string       nm,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] exp
    );
        int cyc;
        logic seen;
        cyc = 0;
        seen = 0;
        issue_mul(a, b);
        while (bus.ex_busy && cyc < 40) begin
            if (bus.out_valid) seen = 1;
            cyc++;
            tick();
        end
        chk({nm, " busy_cycles"}, 64'(cyc), 64'd16);
        chk({nm, " valid_while_busy"}, 64'(seen), 64'd0);
        chk({nm, " valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, " result"}, bus.out_alu_result, exp);
        chk({nm, " rd"}, 64'(bus.out_rd), 64'd9);
        chk({nm, " reg_write"}, 64'(bus.out_reg_write), 64'd1);
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        vt[0]  = mk(OP_ADD, BR_NONE, 1, 0, 5, 0,
                    64'hFFFF_FFFF_FFFF_FFFD, 1, 2,
                    2, 0, 0, 64'hFFFF_FFFF_FFFF_FFF4, 0);
        vt[1]  = mk(OP_SUB, BR_NONE, 0, 0, 1, 10, 0, 3, 3,
                    0, 1, 0, 0, 10);
        vt[1].men = 1; vt[1].mrd = 3; vt[1].mdat = 10;
        vt[1].wen = 1; vt[1].wrd = 3; vt[1].wdat = 20;
        vt[2]  = mk(OP_SUB, BR_NONE, 0, 0, 0, 10, 0, 31, 3,
                    64'hFFFF_FFFF_FFFF_FFF6, 0, 0, 0, 10);
        vt[2].men = 1; vt[2].mrd = 31; vt[2].mdat = 10;
        vt[2].wen = 1; vt[2].wrd = 31; vt[2].wdat = 20;
        vt[3]  = mk(OP_AND, BR_NONE, 0, 0, 64'hF0F0,
                    64'hFF00, 0, 1, 2,
                    64'hF000, 0, 0, 0, 64'hFF00);
        vt[4]  = mk(OP_ORR, BR_NONE, 0, 0, 64'hF0F0,
                    64'h0F00, 0, 1, 2,
                    64'hFFF0, 0, 0, 0, 64'h0F00);
        vt[5]  = mk(OP_NOR, BR_NONE, 0, 0, 0, 0, 0, 1, 2,
                    ONES, 0, 0, 0, 0);
        vt[6]  = mk(OP_PASSB, BR_NONE, 1, 0, 7, 9,
                    64'h1234, 1, 2,
                    64'h1234, 0, 0, 64'h48D0, 9);
        vt[7]  = mk(4'b0011, BR_NONE, 0, 0, 5, 7, 0, 1, 2,
                    0, 1, 0, 0, 7);
        vt[8]  = mk(OP_ADD, BR_NONE, 0, 0, 100, 2, 0, 4, 2,
                    3, 0, 0, 0, 2);
        vt[8].men = 1; vt[8].mrd = 7; vt[8].mdat = 9;
        vt[8].wen = 1; vt[8].wrd = 4; vt[8].wdat = 1;
        vt[9]  = mk(OP_ADD, BR_NONE, 0, 0, 3, 4, 0, 1, 2,
                    7, 0, 0, 0, 4);
        vt[9].men = 0; vt[9].mrd = 1; vt[9].mdat = 50;
        vt[9].wen = 0; vt[9].wrd = 1; vt[9].wdat = 60;
        vt[10] = mk(OP_PASSB, BR_CBZ, 0, 64'h100, 0, 0, 4,
                    1, 2, 0, 1, 1, 64'h110, 0);
        vt[11] = mk(OP_PASSB, BR_CBNZ, 0, 64'h100, 0, 0, 4,
                    1, 2, 0, 1, 0, 64'h110, 0);
        vt[12] = mk(OP_PASSB, BR_B, 0, 64'h100, 0, 5, 4,
                    1, 2, 5, 0, 1, 64'h110, 5);
        vt[13] = mk(OP_PASSB, BR_CBNZ, 0, 64'h100, 0, 5, 4,
                    1, 2, 5, 0, 1, 64'h110, 5);
        vt[14] = mk(OP_ADD, BR_NONE, 1, 0, ONES, 0, 1, 1, 2,
                    0, 1, 0, 4, 0);
        vt[15] = mk(OP_PASSB, BR_B, 0,
                    64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1,
                    1, 2, 0, 1, 1, 0, 0);

        clr();
        reset = 1;
        tick();
        tick();
        chk("rst valid", 64'(bus.out_valid), 0);
        chk("rst busy", 64'(bus.ex_busy), 0);
        chk("rst result", bus.out_alu_result, 0);
        chk("rst taken", 64'(bus.out_br_taken), 0);
        chk("rst reg_write", 64'(bus.out_reg_write), 0);
        reset = 0;
        tick();
        chk("idle bubble", 64'(bus.out_valid), 0);

        for (int i = 0; i < 16; i++) begin
            drive(vt[i], 5'(i));
            bus.in_valid = 1;
            tick();
            chk($sformatf("v%0d valid", i),
                64'(bus.out_valid), 1);
            chk($sformatf("v%0d res", i),
                bus.out_alu_result, vt[i].e_res);
            chk($sformatf("v%0d zero", i),
                64'(bus.out_zero), 64'(vt[i].e_zero));
            chk($sformatf("v%0d taken", i),
                64'(bus.out_br_taken), 64'(vt[i].e_taken));
            chk($sformatf("v%0d tgt", i),
                bus.out_br_target, vt[i].e_tgt);
            chk($sformatf("v%0d wdata", i),
                bus.out_write_data, vt[i].e_wd);
            chk($sformatf("v%0d rd", i),
                64'(bus.out_rd), 64'(i));
        end

        drive(vt[0], 5'd3);
        bus.in_valid = 1;
        bus.mem_stall = 1;
        tick();
        chk("stall hold valid", 64'(bus.out_valid), 1);
        chk("stall hold res", bus.out_alu_result, 0);
        chk("stall hold taken", 64'(bus.out_br_taken), 1);
        chk("stall hold rd", 64'(bus.out_rd), 15);
        bus.mem_stall = 0;
        tick();
        chk("after stall res", bus.out_alu_result, 2);
        bus.flush = 1;
        tick();
        chk("flush bubble valid", 64'(bus.out_valid), 0);
        chk("flush bubble rw", 64'(bus.out_reg_write), 0);
        bus.flush = 0;
        bus.in_valid = 0;
        tick();
        chk("no-input bubble", 64'(bus.out_valid), 0);

        run_mul("mul7x6", 7, 6, 42);
        run_mul("mulwrap", ONES, 2, 64'hFFFF_FFFF_FFFF_FFFE);

        issue_mul(3, 5);
        repeat (9) tick();
        bus.mem_stall = 1;
        repeat (11) tick();
        chk("done busy", 64'(bus.ex_busy), 1);
        chk("done valid", 64'(bus.out_valid), 0);
        chk("done rw", 64'(bus.out_reg_write), 0);
        bus.mem_stall = 0;
        tick();
        chk("done load valid", 64'(bus.out_valid), 1);
        chk("done load res", bus.out_alu_result, 15);
        chk("done load busy", 64'(bus.ex_busy), 0);
        tick();
        chk("done then bubble", 64'(bus.out_valid), 0);

        issue_mul(7, 6);
        repeat (4) tick();
        bus.flush = 1;
        tick();
        bus.flush = 0;
        chk("mflush busy", 64'(bus.ex_busy), 0);
        chk("mflush valid", 64'(bus.out_valid), 0);
        begin
            logic seen;
            seen = 0;
            repeat (20) begin
                tick();
                if (bus.out_valid) seen = 1;
            end
            chk("mflush no product", 64'(seen), 0);
        end
        clr();
        bus.in_alu_op = OP_ADD; bus.in_alu_src = 1;
        bus.in_rs1_data = 40; bus.in_imm = 2;
        bus.in_pc = 64'h20; bus.in_rs2_data = 64'h77;
        bus.in_rd = 4; bus.in_reg_write = 1;
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        chk("post flush valid", 64'(bus.out_valid), 1);
        chk("post flush res", bus.out_alu_result, 42);

        issue_mul(7, 6);
        repeat (4) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("mrst valid", 64'(bus.out_valid), 0);
        chk("mrst busy", 64'(bus.ex_busy), 0);
        chk("mrst res", bus.out_alu_result, 0);
        chk("mrst tgt", bus.out_br_target, 0);
        chk("mrst wdata", bus.out_write_data, 0);
        chk("mrst rd", 64'(bus.out_rd), 0);
        chk("mrst rw", 64'(bus.out_reg_write), 0);
        run_mul("mul after rst", 9, 9, 81);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
